// File: rtl/convb_param_loader.sv
// ConvB parameter loader.
// Takes one stream of weight and bias words and spreads it over the per-unit
// weight and bias memories, one filter at a time, round-robin across the units.
// It also holds back the stage start until a complete parameter set is loaded.
//
// Handshake: a word transfers on every rising edge where s_valid and s_ready
// are both 1. s_data must be stable while s_valid is high. s_ready is decoded
// straight from the state register. The producer may hold s_valid low for any
// number of cycles; the loader simply waits.
//
// Stream order: first the weights of filters 0..F-1, N words per filter, in
// memory order. Then one bias per filter, filters 0..F-1.
// Filter f goes to unit f mod U, slot f div U.
// Weight word i of filter f is written to address slot*N + i of the weight
// memory of that unit. The bias of filter f is written to address slot of the
// bias memory of that unit.
module convb_param_loader #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_BITS      = 15,
  parameter int IFM_DEPTH         = 3,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 6,
  parameter int NUMBER_OF_UNITS   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_WIDTH-1:0]      riscv_data,
  output logic [ADDRESS_BITS-1:0]    riscv_address,
  output logic [NUMBER_OF_UNITS-1:0] wm_enable_write,
  output logic [NUMBER_OF_UNITS-1:0] bm_enable_write,
  output logic                       busy,
  output logic                       params_valid,
  output logic                       load_done,
  input  logic                       start_from_previous,
  output logic                       start_to_conv,
  output logic [1:0]                 state_dbg
);

  localparam int N  = KERNAL_SIZE * KERNAL_SIZE * IFM_DEPTH;
  localparam int F  = NUMBER_OF_FILTERS;
  localparam int U  = NUMBER_OF_UNITS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (F > 1) ? $clog2(F) : 1;
  localparam int UW = (U > 1) ? $clog2(U) : 1;

  localparam logic [IW-1:0]           I_LAST = IW'(N - 1);
  localparam logic [FW-1:0]           F_LAST = FW'(F - 1);
  localparam logic [UW-1:0]           U_LAST = UW'(U - 1);
  localparam logic [ADDRESS_BITS-1:0] N_ADDR = ADDRESS_BITS'(N);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             i_q, i_d;
  logic [FW-1:0]             f_q, f_d;
  // unit/slot/base follow f incrementally, so there is no divider in the address path
  logic [UW-1:0]             unit_q, unit_d;
  logic [ADDRESS_BITS-1:0]   slot_q, slot_d;
  logic [ADDRESS_BITS-1:0]   base_q, base_d;
  logic                      pv_q, pv_d;
  logic                      pend_q, pend_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [ADDRESS_BITS-1:0]   addr_q, addr_d;
  logic [U-1:0]              wm_q, wm_d;
  logic [U-1:0]              bm_q, bm_d;
  logic                      done_q, done_d;
  logic                      start_q, start_d;
  logic [U-1:0]              unit_onehot;
  logic                      accept;

  assign s_ready         = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B);
  assign busy            = s_ready;
  assign accept          = s_valid && s_ready;
  assign riscv_data      = data_q;
  assign riscv_address   = addr_q;
  assign wm_enable_write = wm_q;
  assign bm_enable_write = bm_q;
  assign params_valid    = pv_q;
  assign load_done       = done_q;
  assign start_to_conv   = start_q;
  assign state_dbg       = state_q;

  // Decode the current unit into its one-hot write strobe.
  always_comb begin
    unit_onehot = '0;
    for (int k = 0; k < U; k++) begin
      unit_onehot[k] = (unit_q == UW'(k));
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      f_q     <= '0;
      unit_q  <= '0;
      slot_q  <= '0;
      base_q  <= '0;
      pv_q    <= 1'b0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      wm_q    <= '0;
      bm_q    <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      f_q     <= f_d;
      unit_q  <= unit_d;
      slot_q  <= slot_d;
      base_q  <= base_d;
      pv_q    <= pv_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wm_q    <= wm_d;
      bm_q    <= bm_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  // Next state, counter advance, memory writes and start gating.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    f_d     = f_q;
    unit_d  = unit_q;
    slot_d  = slot_q;
    base_d  = base_q;
    pv_d    = pv_q;
    pend_d  = pend_q;
    data_d  = '0;
    addr_d  = '0;
    wm_d    = '0;
    bm_d    = '0;
    done_d  = 1'b0;
    start_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_start) begin
          // A new load wins over a same-cycle start; that start is kept as pending.
          state_d = ST_LOAD_W;
          i_d     = '0;
          f_d     = '0;
          unit_d  = '0;
          slot_d  = '0;
          base_d  = '0;
          pv_d    = 1'b0;
          if (start_from_previous) pend_d = 1'b1;
        end else if (state_q == ST_DONE) begin
          start_d = start_from_previous;
        end else if (start_from_previous) begin
          pend_d = 1'b1;
        end
      end

      ST_LOAD_W: begin
        if (start_from_previous) pend_d = 1'b1;
        if (accept) begin
          data_d = s_data;
          addr_d = base_q + ADDRESS_BITS'(i_q);
          wm_d   = unit_onehot;
          if (i_q == I_LAST) begin
            i_d = '0;
            if (f_q == F_LAST) begin
              state_d = ST_LOAD_B;
              f_d     = '0;
              unit_d  = '0;
              slot_d  = '0;
              base_d  = '0;
            end else begin
              f_d = f_q + 1'b1;
              if (unit_q == U_LAST) begin
                unit_d = '0;
                slot_d = slot_q + 1'b1;
                base_d = base_q + N_ADDR;
              end else begin
                unit_d = unit_q + 1'b1;
              end
            end
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end

      ST_LOAD_B: begin
        if (start_from_previous) pend_d = 1'b1;
        if (accept) begin
          data_d = s_data;
          addr_d = slot_q;
          bm_d   = unit_onehot;
          if (f_q == F_LAST) begin
            // The last bias completes the set; any held start is released now.
            state_d = ST_DONE;
            pv_d    = 1'b1;
            done_d  = 1'b1;
            start_d = pend_q || start_from_previous;
            pend_d  = 1'b0;
          end else begin
            f_d = f_q + 1'b1;
            if (unit_q == U_LAST) begin
              unit_d = '0;
              slot_d = slot_q + 1'b1;
            end else begin
              unit_d = unit_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/convb_param_loader.md
# convb_param_loader

Configuration sequencer for the ConvB convolution stage. It accepts a single valid/ready stream of weight and bias words from the RISC-V side and distributes them round-robin by filter into the per-unit weight and bias memories. It drives the stage's `riscv_data`, `riscv_address`, `wm_enable_write` and `bm_enable_write` inputs. It also gates the stage start so convolution never begins on a partially loaded parameter set.

## Interface
- DATA_WIDTH, 32, parameter word width
- ADDRESS_BITS, 15, width of the memory write address
- IFM_DEPTH, 3, input channels per filter
- KERNAL_SIZE, 5, kernel edge length
- NUMBER_OF_FILTERS, 6, total filters F
- NUMBER_OF_UNITS, 3, parallel conv units U

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle pulse that begins a full parameter load
- s_data  in  DATA_WIDTH  parameter word
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts a word this cycle
- riscv_data  out  DATA_WIDTH  write data to the stage memories
- riscv_address  out  ADDRESS_BITS  write address within the selected unit memory
- wm_enable_write  out  U  one-hot weight-memory write strobe
- bm_enable_write  out  U  one-hot bias-memory write strobe
- busy  out  1  load in progress
- params_valid  out  1  a complete parameter set is resident
- load_done  out  1  one-cycle pulse when a load completes
- start_from_previous  in  1  start request from the upstream stage
- start_to_conv  out  1  gated start pulse to the ConvB stage

## Operation
- Definitions:
  - N = KERNAL_SIZE·KERNAL_SIZE·IFM_DEPTH (75 at defaults).
  - Stream order: all weights for filter 0..F-1, N words per filter, in memory order; then F biases, filter 0..F-1. Total words = F·N + F (456 at defaults).
- Mapping for filter f:
  - unit = f mod U, slot = f div U.
  - Weight word i of filter f goes to address slot·N + i of unit memory `unit`.
  - The bias of filter f goes to address slot of bias memory `unit`.
- FSM states: IDLE, LOAD_W, LOAD_B, DONE.
  - IDLE/DONE → LOAD_W on cfg_start. This clears params_valid and the counters (word index i, filter f).
  - LOAD_W: each accepted word writes to the weight memory, then i++. When i = N-1, set i = 0 and f++. After the last weight of filter F-1, go to LOAD_B with f = 0.
  - LOAD_B: each accepted word writes to the bias memory, then f++. The last bias goes to DONE and sets params_valid.
  - DONE holds until the next cfg_start.
- Counters advance only on accept (s_valid & s_ready). s_valid low stalls the load with no timeout.
- cfg_start while busy is ignored.
- Start gating:
  - In DONE, start_from_previous passes through as start_to_conv.
  - A start_from_previous while params_valid = 0 sets a pending flag. The pending start issues as a one-cycle start_to_conv on the first DONE cycle, and the flag then clears.
  - cfg_start and start_from_previous in the same DONE cycle: the load wins, the start becomes pending, and start_to_conv stays 0.
- Address arithmetic: slot·N + i is computed in ADDRESS_BITS and never exceeds ceil(F/U)·N - 1. Upper bits are zero-extended.

## Timing
- Reset values (asynchronous on reset = 0): state IDLE, all counters 0, pending 0. Outputs: s_ready 0, riscv_data 0, riscv_address 0, wm_enable_write 0, bm_enable_write 0, busy 0, params_valid 0, load_done 0, start_to_conv 0.
- s_ready is 1 exactly in LOAD_W and LOAD_B. It is registered and goes high the cycle after cfg_start is sampled.
- Write latency:
  - A word accepted in cycle n produces registered riscv_data, riscv_address and a one-hot strobe in cycle n+1, for exactly one cycle.
  - At most one strobe bit across both strobe buses is high in any cycle.
- busy is 1 in LOAD_W and LOAD_B.
- The last bias is accepted in cycle n. In cycle n+1 the bias write strobe fires, the state is DONE, params_valid = 1, load_done = 1, and a pending start_to_conv fires.
- start_to_conv passthrough in DONE is registered: 1 cycle latency from start_from_previous.
- Reset deasserted mid-load: the next load restarts from word 0. Partial memory contents are not cleared but params_valid stays 0.

## Test plan
- Reset then cfg_start, then stream 456 words (value = index) with s_valid held high. Required:
  - 450 wm strobes, then 6 bm strobes.
  - Word 75 goes to unit1 address 0; word 225 goes to unit0 address 75; word 449 goes to unit2 address 149.
  - Bias words 450..455 go to units 0,1,2,0,1,2 at addresses 0,0,0,1,1,1.
  - load_done pulses once, one cycle after word 455 is accepted.
- Same load with s_valid toggled randomly at 50%: write sequence identical to the previous test, with no duplicate or skipped addresses.
- start_from_previous pulse at word 100 of a load: start_to_conv stays 0 during the load, then fires exactly once in the cycle params_valid rises.
- In DONE, cfg_start and start_from_previous in the same cycle: params_valid drops and start_to_conv stays 0. After the 456-word reload, start_to_conv fires once.
- Assert reset at word 300, release, then perform a full reload:
  - All outputs are 0 during reset.
  - The reload starts at unit0 address 0 and completes with params_valid = 1.
- cfg_start pulses during LOAD_W: no counter reset, and the total strobe count stays 456.
